capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter DEPTH, default 512: number of sample RAM entries; SHALL be a power of two from 16 to 4096.
REQ-002 Parameter ADDR_W, default $clog2(DEPTH): width of the write address.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1: system clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port run, input, 1: capture-enable level from the trigger-config register.
REQ-007 Port en_smpl, input, 1: one-cycle sample strobe from the decimator.
REQ-008 Port trig, input, 1: combined channel/protocol trigger level.
REQ-009 Port trig_pos, input, ADDR_W: number of samples to store after the trigger.
REQ-010 Port clr_cap_done, input, 1: one-cycle pulse from the command decoder acknowledging a finished capture.
REQ-011 Port we, output, 1: sample RAM write enable.
REQ-012 Port waddr, output, ADDR_W: sample RAM write address.
REQ-013 Port armed, output, 1: the pre-trigger region is filled and the trigger is being accepted.
REQ-014 Port triggered, output, 1: the trigger has been accepted for the current capture.
REQ-015 Port capture_done, output, 1: capture complete; the RAM holds a valid record.
REQ-016 Port rd_start, output, ADDR_W: oldest-sample address of the completed record, for dump.

Function
REQ-017 States: IDLE, FILL, ARMED, POST, DONE.
REQ-018 IDLE -> FILL when run=1 and capture_done=0; waddr and smpl_cnt clear to 0 on entry.
REQ-019 In FILL, ARMED and POST: we = en_smpl, combinational, in the same cycle; waddr increments by 1 on each en_smpl edge and wraps from DEPTH-1 to 0.
REQ-020 In IDLE and DONE: we=0 and waddr holds.
REQ-021 FILL: smpl_cnt increments per en_smpl, saturating at DEPTH; FILL -> ARMED on the edge at which smpl_cnt+1 >= DEPTH - tp, where tp = min(trig_pos, DEPTH-1).
REQ-022 armed SHALL be registered and asserted exactly in ARMED.
REQ-023 ARMED -> POST on the first clk edge with trig=1, independent of en_smpl; triggered sets on that edge; post_cnt clears.
REQ-024 trig SHALL be ignored in IDLE, FILL, POST and DONE.
REQ-025 Trig and en_smpl in the same ARMED cycle: that sample is written and counts as pre-trigger; post_cnt starts at 0.
REQ-026 POST: post_cnt increments per en_smpl; POST -> DONE on the edge where post_cnt reaches tp.
REQ-027 If tp=0, ARMED -> DONE directly on the trigger edge.
REQ-028 On DONE entry: capture_done sets, and rd_start loads the post-increment waddr, which is the oldest sample.
REQ-029 DONE -> IDLE on clr_cap_done=1; capture_done, triggered and armed clear.
REQ-030 clr_cap_done outside DONE SHALL be ignored, including in the same cycle as DONE entry.
REQ-031 run=0 in FILL, ARMED or POST: next edge -> IDLE, with armed, triggered and counters cleared.
REQ-032 run=0 in DONE: stay in DONE; the record is preserved.
REQ-033 trig_pos SHALL be sampled into a register on FILL entry; later changes have no effect until the next capture.
REQ-034 Counters SHALL be ADDR_W+1 bits wide; no arithmetic overflow is permitted.

Reset
REQ-035 rst=1 asynchronously forces IDLE and sets waddr, rd_start, smpl_cnt and post_cnt to 0; we, armed, triggered and capture_done go to 0.
REQ-036 Reset asserted mid-capture SHALL discard the capture; the first FILL after release starts at waddr=0.

Structure
REQ-037 Package la_pkg SHALL hold the cap_state_t enum (IDLE, FILL, ARMED, POST, DONE) and the DEPTH_DEF=512 constant.
REQ-038 One sub-module, wrap_cntr (an ADDR_W-bit counter with increment enable, synchronous clear and modulo-DEPTH wrap), SHALL be used for waddr.
REQ-039 All other logic SHALL be flat inside capture_ctrl.

Verification
REQ-040 DEPTH=16, trig_pos=4, run=1, en_smpl every cycle, trig held 0: armed SHALL rise after the 12th write; waddr wraps 15 -> 0; capture_done stays 0.
REQ-041 Same setup plus trig pulse with waddr=5 in ARMED: 4 more writes; capture_done=1; rd_start=10; we=0 thereafter.
REQ-042 trig_pos=0, trigger at waddr=7 with en_smpl=1: DONE on the next edge; rd_start=8; no further writes.
REQ-043 trig_pos=20 with DEPTH=16: clamped to tp=15; armed after the 1st write; 15 post-trigger writes.
REQ-044 run dropped in POST after 2 of 4 post-trigger samples: IDLE next edge; capture_done=0; triggered=0. Raising run again restarts with waddr=0.
REQ-045 rst pulse with capture_done=1 (no clock edge): all outputs 0 immediately. clr_cap_done issued in the DONE-entry cycle: DONE is held.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture path.
package la_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  localparam int DEPTH_DEF = 512;

endpackage

// File: rtl/wrap_cntr.sv
// Sample RAM address counter: increment enable, synchronous clear, wraps modulo DEPTH.
module wrap_cntr #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic [ADDR_W-1:0] nxt
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // nxt is exported so the owner can capture the post-increment address
  always_comb begin
    nxt = cnt;
    if (clr) begin
      nxt = '0;
    end else if (inc) begin
      nxt = (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: fills a circular sample RAM, arms once the pre-trigger
// region is full, then stores trig_pos post-trigger samples and reports done.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              en_smpl,
  input  logic              trig,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              clr_cap_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done,
  output logic [ADDR_W-1:0] rd_start
);

  localparam int            CW      = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] TP_MAX  = CW'(DEPTH - 1);

  // state is kept as a named enum so checkers can bind to it directly
  cap_state_t        state;
  cap_state_t        state_nxt;
  logic [CW-1:0]     smpl_cnt;
  logic [CW-1:0]     post_cnt;
  logic [CW-1:0]     tp_reg;
  logic [CW-1:0]     tp_in;
  logic [ADDR_W-1:0] waddr_nxt;
  logic              capturing;
  logic              fill_start;

  assign tp_in      = ({1'b0, trig_pos} > TP_MAX) ? TP_MAX : {1'b0, trig_pos};
  assign capturing  = (state == FILL) || (state == ARMED) || (state == POST);
  assign we         = capturing && en_smpl;
  assign fill_start = (state == IDLE) && (state_nxt == FILL);

  wrap_cntr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_waddr (
    .clk (clk),
    .rst (rst),
    .clr (fill_start),
    .inc (we),
    .cnt (waddr),
    .nxt (waddr_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (run && !capture_done) state_nxt = FILL;
      FILL: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (en_smpl && (smpl_cnt + CW'(1) >= DEPTH_C - tp_reg)) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        // the sample written in the trigger cycle belongs to the pre-trigger part
        if (!run) begin
          state_nxt = IDLE;
        end else if (trig) begin
          state_nxt = (tp_reg == '0) ? DONE : POST;
        end
      end
      POST: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (en_smpl && (post_cnt + CW'(1) >= tp_reg)) begin
          state_nxt = DONE;
        end
      end
      DONE:    if (clr_cap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      smpl_cnt     <= '0;
      post_cnt     <= '0;
      tp_reg       <= '0;
      armed        <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
      rd_start     <= '0;
    end else begin
      state        <= state_nxt;
      armed        <= (state_nxt == ARMED);
      triggered    <= (state_nxt == POST) || (state_nxt == DONE);
      capture_done <= (state_nxt == DONE);

      if (fill_start) begin
        tp_reg <= tp_in;
      end

      if ((state == IDLE) || (state_nxt == IDLE)) begin
        smpl_cnt <= '0;
      end else if ((state == FILL) && en_smpl && (smpl_cnt != DEPTH_C)) begin
        smpl_cnt <= smpl_cnt + CW'(1);
      end

      if ((state == POST) && (state_nxt == POST)) begin
        if (en_smpl) begin
          post_cnt <= post_cnt + CW'(1);
        end
      end else begin
        post_cnt <= '0;
      end

      // the next write address is the oldest sample of the finished record
      if ((state != DONE) && (state_nxt == DONE)) begin
        rd_start <= waddr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a sample-count model checked every cycle.
module tb_capture_ctrl;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              en_smpl = 1'b0;
  logic              trig = 1'b0;
  logic [ADDR_W-1:0] trig_pos = '0;
  logic              clr_cap_done = 1'b0;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              armed;
  logic              triggered;
  logic              capture_done;
  logic [ADDR_W-1:0] rd_start;

  int n_checks = 0;
  int n_fail   = 0;
  bit en_cmp   = 1'b0;

  // model: capture progress expressed as sample counts
  bit m_cap, m_done, m_trg;
  int m_pre, m_post, m_addr, m_rd, m_tp;

  capture_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .en_smpl      (en_smpl),
    .trig         (trig),
    .trig_pos     (trig_pos),
    .clr_cap_done (clr_cap_done),
    .we           (we),
    .waddr        (waddr),
    .armed        (armed),
    .triggered    (triggered),
    .capture_done (capture_done),
    .rd_start     (rd_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_done = 0; m_trg = 0;
    m_pre = 0; m_post = 0; m_addr = 0; m_rd = 0; m_tp = 0;
  endtask

  function automatic bit m_armed();
    return m_cap && !m_trg && (m_pre >= DEPTH - m_tp);
  endfunction

  // advance the model across one rising edge using the inputs held before it
  task automatic model_edge();
    bit arm_now;
    int tpv;
    arm_now = m_armed();
    tpv     = int'(trig_pos);
    if (m_done) begin
      if (clr_cap_done) begin
        m_done = 0;
        m_trg  = 0;
      end
    end else if (!m_cap) begin
      if (run) begin
        m_cap = 1; m_trg = 0; m_pre = 0; m_post = 0; m_addr = 0;
        m_tp  = (tpv > DEPTH - 1) ? DEPTH - 1 : tpv;
      end
    end else begin
      if (en_smpl) begin
        m_addr = (m_addr + 1) % DEPTH;
        if (m_trg) m_post++;
        else       m_pre++;
      end
      if (!run) begin
        m_cap = 0; m_trg = 0; m_pre = 0; m_post = 0;
      end else begin
        if (arm_now && trig) begin
          m_trg  = 1;
          m_post = 0;
        end
        if (m_trg && (m_post >= m_tp)) begin
          m_done = 1;
          m_cap  = 0;
          m_rd   = m_addr;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("we",           int'(we),           int'(m_cap && en_smpl));
      chk("waddr",        int'(waddr),        m_addr);
      chk("armed",        int'(armed),        int'(m_armed()));
      chk("triggered",    int'(triggered),    int'(m_trg));
      chk("capture_done", int'(capture_done), int'(m_done));
      chk("rd_start",     int'(rd_start),     m_rd);
    end
  end

  // inputs change 1 time unit after the rising edge and hold for a full cycle
  task automatic step(input bit r, input bit e, input bit t, input bit c);
    run = r; en_smpl = e; trig = t; clr_cap_done = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    en_cmp = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset waddr", int'(waddr), 0);
    chk("reset capture_done", int'(capture_done), 0);
    chk("reset armed", int'(armed), 0);

    // pre-trigger fill with tp=4: armed after the 12th write, waddr wraps
    trig_pos = 5'd4;
    step(1, 1, 0, 0);
    chk("A fill start waddr", int'(waddr), 0);
    repeat (11) step(1, 1, 0, 0);
    chk("A armed after 11", int'(armed), 0);
    step(1, 1, 0, 0);
    chk("A armed after 12", int'(armed), 1);
    repeat (4) step(1, 1, 0, 0);
    chk("A wrap waddr", int'(waddr), 0);
    chk("A no done", int'(capture_done), 0);

    // trigger at waddr=5, then 4 post-trigger writes
    repeat (5) step(1, 1, 0, 0);
    chk("B trig waddr", int'(waddr), 5);
    step(1, 1, 1, 0);
    chk("B triggered", int'(triggered), 1);
    repeat (3) step(1, 1, 0, 0);
    chk("B not done at 3", int'(capture_done), 0);
    step(1, 1, 0, 0);
    chk("B done", int'(capture_done), 1);
    chk("B rd_start", int'(rd_start), 10);
    repeat (3) step(1, 1, 0, 0);
    chk("B waddr holds", int'(waddr), 10);
    step(0, 0, 0, 1);
    chk("B cleared done", int'(capture_done), 0);
    chk("B cleared trig", int'(triggered), 0);
    step(0, 0, 0, 0);

    // tp=0: trigger at waddr=7 finishes on the same edge; early trig ignored
    trig_pos = 5'd0;
    step(1, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 1, (i == 5), 0);
    chk("C armed after 15", int'(armed), 0);
    step(1, 1, 0, 0);
    chk("C armed after 16", int'(armed), 1);
    repeat (7) step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("C done held", int'(capture_done), 1);
    chk("C rd_start", int'(rd_start), 8);
    repeat (2) step(1, 1, 0, 0);
    chk("C no writes", int'(waddr), 8);
    step(0, 1, 0, 0);
    chk("C run low keeps done", int'(capture_done), 1);
    step(0, 0, 0, 1);
    chk("C cleared", int'(capture_done), 0);

    // trig_pos=20 clamps to 15; a later trig_pos change is ignored
    trig_pos = 5'd20;
    step(1, 1, 0, 0);
    trig_pos = 5'd3;
    step(1, 1, 0, 0);
    chk("D armed after 1", int'(armed), 1);
    step(1, 1, 1, 0);
    repeat (14) step(1, 1, 0, 0);
    chk("D not done at 14", int'(capture_done), 0);
    step(1, 1, 0, 0);
    chk("D done at 15", int'(capture_done), 1);
    chk("D rd_start", int'(rd_start), 1);
    step(0, 0, 0, 1);

    // sparse strobes, trigger without a strobe, abort in POST
    trig_pos = 5'd4;
    step(1, 1, 0, 0);
    for (int i = 0; i < 24; i++) step(1, (i % 2 == 0), 0, 0);
    chk("E armed", int'(armed), 1);
    step(1, 0, 1, 0);
    chk("E trig no write", int'(waddr), 12);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("E abort triggered", int'(triggered), 0);
    chk("E abort done", int'(capture_done), 0);
    step(1, 0, 0, 0);
    chk("E restart waddr", int'(waddr), 0);
    step(0, 0, 0, 0);

    // asynchronous reset while a finished record is held
    trig_pos = 5'd15;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    repeat (15) step(1, 1, 0, 0);
    chk("F done", int'(capture_done), 1);
    rst = 1'b1;
    model_reset();
    #2;
    chk("F rst we", int'(we), 0);
    chk("F rst waddr", int'(waddr), 0);
    chk("F rst armed", int'(armed), 0);
    chk("F rst triggered", int'(triggered), 0);
    chk("F rst done", int'(capture_done), 0);
    chk("F rst rd_start", int'(rd_start), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 1, 0, 0);
    chk("F refill waddr", int'(waddr), 0);
    repeat (3) step(1, 1, 0, 0);
    chk("F refill progress", int'(waddr), 3);
    step(0, 0, 0, 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
